// File: rtl/bandai_so_rx_if.sv
// Signal bundle between the cartridge serial receiver and its host logic.
// VALID and FERR are single-cycle pulses with no back-pressure; WORD holds the last good frame.
interface bandai_so_rx_if;
    logic        SI;
    logic        EN;
    logic        CLR;
    logic [15:0] WORD;
    logic        VALID;
    logic        FERR;
    logic        MATCH;
    logic        BUSY;
    logic [3:0]  FCNT;
    logic [1:0]  STATE;

    modport master (
        output SI, EN, CLR,
        input  WORD, VALID, FERR, MATCH, BUSY, FCNT, STATE
    );

    modport slave (
        input  SI, EN, CLR,
        output WORD, VALID, FERR, MATCH, BUSY, FCNT, STATE
    );
endinterface

// File: rtl/bandai_so_rx.sv
// Receiver for the cartridge serial-out line: 0-start, 16 data bits LSB first, 0-end, idle high.
// Requires IDLE_MIN idle ones before each start bit; flags a match against the unlock word.
module bandai_so_rx #(
    parameter int          SYNC_STAGES = 2,
    parameter int          IDLE_MIN    = 4,
    parameter logic [15:0] EXPECT      = 16'h28A0
) (
    input  logic          CLK,
    input  logic          RST,
    bandai_so_rx_if.slave bus
);
    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        DATA = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam logic [3:0] IDLE_MIN_C = 4'(IDLE_MIN);

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [3:0]             idle_cnt;
    logic [3:0]             bit_cnt;
    logic [15:0]            shreg;
    logic [15:0]            word_q;
    logic                   valid_q;
    logic                   ferr_q;
    logic                   match_q;
    logic [3:0]             fcnt_q;
    logic                   hit;

    assign s   = sync[SYNC_STAGES-1];
    assign hit = (shreg == EXPECT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync     <= '1;
            state    <= ARM;
            idle_cnt <= 4'd0;
            bit_cnt  <= 4'd0;
            shreg    <= 16'h0000;
            word_q   <= 16'h0000;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            match_q  <= 1'b0;
            fcnt_q   <= 4'd0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], bus.SI};
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (bus.CLR) begin
                match_q <= 1'b0;
                fcnt_q  <= 4'd0;
            end
            if (!bus.EN) begin
                state    <= ARM;
                idle_cnt <= 4'd0;
                bit_cnt  <= 4'd0;
            end else begin
                case (state)
                    ARM: begin
                        // A low line here is never a start bit; it only restarts the idle count.
                        if (s) begin
                            if (idle_cnt + 4'd1 == IDLE_MIN_C) begin
                                state    <= IDLE;
                                idle_cnt <= 4'd0;
                            end else begin
                                idle_cnt <= idle_cnt + 4'd1;
                            end
                        end else begin
                            idle_cnt <= 4'd0;
                        end
                    end
                    IDLE: begin
                        if (!s) begin
                            state   <= DATA;
                            bit_cnt <= 4'd0;
                        end
                    end
                    DATA: begin
                        shreg   <= {s, shreg[15:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) state <= STOP;
                    end
                    STOP: begin
                        // A coincident CLR loses to the completing frame: the frame counts from zero.
                        if (!s) begin
                            word_q  <= shreg;
                            valid_q <= 1'b1;
                            match_q <= hit | (match_q & ~bus.CLR);
                            if (bus.CLR)             fcnt_q <= 4'd1;
                            else if (fcnt_q != 4'hF) fcnt_q <= fcnt_q + 4'd1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                        state    <= ARM;
                        idle_cnt <= 4'd0;
                    end
                    default: state <= ARM;
                endcase
            end
        end
    end

    assign bus.WORD  = word_q;
    assign bus.VALID = valid_q;
    assign bus.FERR  = ferr_q;
    assign bus.MATCH = match_q;
    assign bus.FCNT  = fcnt_q;
    assign bus.BUSY  = (state == DATA) || (state == STOP);
    assign bus.STATE = state;
endmodule

// File: tb/tb_bandai_so_rx.sv
// Bench for bandai_so_rx: a bit-stream frame decoder model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_bandai_so_rx;
    localparam int          SYNC   = 2;
    localparam int          IDLE_N = 4;
    localparam logic [15:0] EXP_W  = 16'h28A0;

    logic CLK;
    logic RST;
    bandai_so_rx_if bus();

    bandai_so_rx #(
        .SYNC_STAGES(SYNC),
        .IDLE_MIN   (IDLE_N),
        .EXPECT     (EXP_W)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int n_valid = 0;
    int n_ferr  = 0;
    int last_pulse_cyc = 0;
    int start_cyc = 0;
    bit busy_seen = 1'b0;
    bit chk_en = 1'b0;

    // Model: line delayed by the synchronizer depth, then decoded as "run of ones, then 17 bits after a 0".
    bit          dly [SYNC];
    bit          m_s;
    int          m_run = 0;
    bit          m_collect = 1'b0;
    bit          m_bits [$];
    logic [15:0] m_w;
    logic [15:0] exp_word  = 16'h0000;
    logic        exp_valid = 1'b0;
    logic        exp_ferr  = 1'b0;
    logic        exp_match = 1'b0;
    logic [3:0]  exp_fcnt  = 4'd0;

    always @(posedge CLK) begin
        m_s = dly[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) dly[i] = dly[i-1];
        dly[0] = bus.SI;
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
        if (RST) begin
            for (int i = 0; i < SYNC; i++) dly[i] = 1'b1;
            m_run = 0;
            m_collect = 1'b0;
            m_bits.delete();
            exp_word  = 16'h0000;
            exp_match = 1'b0;
            exp_fcnt  = 4'd0;
        end else begin
            if (bus.CLR) begin
                exp_match = 1'b0;
                exp_fcnt  = 4'd0;
            end
            if (!bus.EN) begin
                m_run = 0;
                m_collect = 1'b0;
                m_bits.delete();
            end else if (m_collect) begin
                m_bits.push_back(m_s);
                if (m_bits.size() == 17) begin
                    if (m_bits[16] == 1'b0) begin
                        for (int i = 0; i < 16; i++) m_w[i] = m_bits[i];
                        exp_word  = m_w;
                        exp_valid = 1'b1;
                        if (exp_fcnt < 4'd15) exp_fcnt = exp_fcnt + 4'd1;
                        if (m_w == EXP_W) exp_match = 1'b1;
                    end else begin
                        exp_ferr = 1'b1;
                    end
                    m_collect = 1'b0;
                    m_bits.delete();
                    m_run = 0;
                end
            end else if (m_run >= IDLE_N && m_s == 1'b0) begin
                m_collect = 1'b1;
                m_bits.delete();
            end else if (m_s) begin
                if (m_run < IDLE_N) m_run++;
            end else begin
                m_run = 0;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    always @(posedge CLK) begin
        #1;
        cyc++;
        if (bus.VALID === 1'b1) begin n_valid++; last_pulse_cyc = cyc; end
        if (bus.FERR === 1'b1)  begin n_ferr++;  last_pulse_cyc = cyc; end
        if (bus.BUSY === 1'b1) busy_seen = 1'b1;
        if (chk_en) begin
            check("WORD",  bus.WORD,  exp_word);
            check("VALID", 16'(bus.VALID), 16'(exp_valid));
            check("FERR",  16'(bus.FERR),  16'(exp_ferr));
            check("MATCH", 16'(bus.MATCH), 16'(exp_match));
            check("BUSY",  16'(bus.BUSY),  16'(m_collect));
            check("FCNT",  16'(bus.FCNT),  16'(exp_fcnt));
            check("VALID_FERR_EXCL", 16'(bus.VALID & bus.FERR), 16'h0000);
        end
    end

    task automatic send_bit(input logic b);
        bus.SI = b;
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_frame(input logic [15:0] w, input logic endb);
        start_cyc = cyc + 1;
        send_bit(1'b0);
        for (int i = 0; i < 16; i++) send_bit(w[i]);
        send_bit(endb);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.SI = 1'b1;
        @(negedge CLK);
        chk_en = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic check_regs(input string tag, input logic [15:0] w, input logic m, input logic [3:0] f);
        check({tag, "_WORD"},  bus.WORD, w);
        check({tag, "_MATCH"}, 16'(bus.MATCH), 16'(m));
        check({tag, "_FCNT"},  16'(bus.FCNT),  16'(f));
    endtask

    int v0;
    int f0;
    logic [15:0] w_rst;
    logic [15:0] fw;

    initial begin
        RST = 1'b1;
        bus.SI  = 1'b1;
        bus.EN  = 1'b1;
        bus.CLR = 1'b0;

        do_reset();
        check_regs("RESET", 16'h0000, 1'b0, 4'd0);
        check("RESET_BUSY", 16'(bus.BUSY), 16'h0000);
        check("RESET_STATE", 16'(bus.STATE), 16'h0000);

        // Good unlock frame.
        idle(8);
        v0 = n_valid; f0 = n_ferr;
        send_frame(16'h28A0, 1'b0);
        idle(6);
        check("S1_NVALID", 16'(n_valid - v0), 16'd1);
        check("S1_NFERR",  16'(n_ferr - f0),  16'd0);
        check("S1_LATENCY", 16'(last_pulse_cyc - start_cyc), 16'd19);
        check_regs("S1", 16'h28A0, 1'b1, 4'd1);

        // Same frame with a bad end bit.
        do_reset();
        idle(8);
        v0 = n_valid; f0 = n_ferr;
        send_frame(16'h28A0, 1'b1);
        idle(6);
        check("S2_NVALID", 16'(n_valid - v0), 16'd0);
        check("S2_NFERR",  16'(n_ferr - f0),  16'd1);
        check("S2_LATENCY", 16'(last_pulse_cyc - start_cyc), 16'd19);
        check_regs("S2", 16'h0000, 1'b0, 4'd0);

        // Line low out of reset, too few ones, then properly armed frame.
        do_reset();
        busy_seen = 1'b0;
        v0 = n_valid; f0 = n_ferr;
        for (int i = 0; i < 10; i++) send_bit(1'b0);
        for (int i = 0; i < 3; i++)  send_bit(1'b1);
        for (int i = 0; i < 4; i++)  send_bit(1'b0);
        check("S3_BUSY_SEEN", 16'(busy_seen), 16'h0000);
        check("S3_NPULSE", 16'((n_valid - v0) + (n_ferr - f0)), 16'd0);
        idle(4);
        send_frame(16'h1234, 1'b0);
        idle(6);
        check("S3_NVALID", 16'(n_valid - v0), 16'd1);
        check_regs("S3", 16'h1234, 1'b0, 4'd1);

        // EN dropped mid-frame, then a clean frame.
        do_reset();
        idle(8);
        v0 = n_valid; f0 = n_ferr;
        fw = 16'h28A0;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(fw[i]);
        bus.EN = 1'b0;
        send_bit(fw[8]);
        send_bit(fw[9]);
        bus.EN = 1'b1;
        for (int i = 10; i < 16; i++) send_bit(fw[i]);
        send_bit(1'b0);
        idle(6);
        check("S4_ABORT_NVALID", 16'(n_valid - v0), 16'd0);
        check("S4_ABORT_NFERR",  16'(n_ferr - f0),  16'd0);
        send_frame(16'h28A0, 1'b0);
        idle(6);
        check("S4_NVALID", 16'(n_valid - v0), 16'd1);
        check_regs("S4", 16'h28A0, 1'b1, 4'd1);

        // 17 back-to-back frames, CLR on the edge that completes the last.
        do_reset();
        idle(8);
        v0 = n_valid;
        for (int i = 0; i < 16; i++) begin
            fw = (i == 2) ? 16'h28A0 : {8'(i), ~8'(i)};
            send_frame(fw, 1'b0);
            idle(4);
        end
        check("S5_NVALID16", 16'(n_valid - v0), 16'd16);
        check_regs("S5_SAT", {8'd15, ~8'd15}, 1'b1, 4'd15);
        send_frame(16'hBEEF, 1'b0);
        send_bit(1'b1);
        bus.CLR = 1'b1;
        send_bit(1'b1);
        bus.CLR = 1'b0;
        idle(4);
        check("S5_NVALID17", 16'(n_valid - v0), 16'd17);
        check("S5_LATENCY", 16'(last_pulse_cyc - start_cyc), 16'd19);
        check_regs("S5_CLR", 16'hBEEF, 1'b0, 4'd1);

        // Reset at data bit 5, then a normal frame.
        idle(6);
        v0 = n_valid; f0 = n_ferr;
        fw = 16'h5A5A;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(fw[i]);
        RST = 1'b1;
        send_bit(fw[5]);
        RST = 1'b0;
        w_rst = 16'h0000;
        check_regs("S6_RST", w_rst, 1'b0, 4'd0);
        check("S6_RST_BUSY",  16'(bus.BUSY),  16'h0000);
        check("S6_RST_VALID", 16'(bus.VALID), 16'h0000);
        check("S6_RST_FERR",  16'(bus.FERR),  16'h0000);
        idle(6);
        send_frame(16'hA55A, 1'b0);
        idle(6);
        check("S6_NVALID", 16'(n_valid - v0), 16'd1);
        check("S6_NFERR",  16'(n_ferr - f0),  16'd0);
        check_regs("S6", 16'hA55A, 1'b0, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
